// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU scheduler slice.
//   * operand / result widths
//   * ALU opcode encodings (op_t)
//   * scheduler FSM state encodings (state_t)
//   * bit positions of the {OF,ZF,CF,SF} flag vector and a packing helper
package alu_pkg;

  localparam int DATA_W = 4;           // operand width
  localparam int RES_W  = DATA_W + 1;  // result width (carry out included)
  localparam int FLAG_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Flag vector layout: {OF,ZF,CF,SF}
  localparam int FLAG_OF = 3;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_SF = 0;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic of, input logic zf,
                                                   input logic cf, input logic sf);
    logic [FLAG_W-1:0] f;
    f          = '0;
    f[FLAG_OF] = of;
    f[FLAG_ZF] = zf;
    f[FLAG_CF] = cf;
    f[FLAG_SF] = sf;
    return f;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational 4-bit ALU.
// Ports:
//   sel  [2:0]  opcode (op_t encoding from alu_pkg)
//   a, b [3:0]  operands
//   out  [4:0]  result (logic ops zero-extended, compares give 0/1)
//   of, zf, cf, sf  flags; cf/sf come from the adder sum, of = cf ^ sf,
//                   zf = (a == b), produced for every opcode
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  out,
  output logic              of,
  output logic              zf,
  output logic              cf,
  output logic              sf
);

  op_t              op;
  logic [RES_W-1:0] add_sum;
  logic [RES_W-1:0] sub_sum;
  logic [RES_W-1:0] sum;
  logic             sub_ovf;
  logic             lt;

  assign op = op_t'(sel);

  // Subtraction is a + (~b + 1) carried out to 5 bits, so CF here is the
  // "no borrow" carry of the two's-complement add.
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + RES_W'(1);

  // Only ADD uses the plain sum; every other opcode reports flags from
  // the subtraction adder.
  assign sum = (op == OP_ADD) ? add_sum : sub_sum;

  // Signed less-than from the 4-bit difference: N xor V.
  assign sub_ovf = (a[DATA_W-1] ^ b[DATA_W-1]) & (sub_sum[DATA_W-1] ^ a[DATA_W-1]);
  assign lt      = sub_sum[DATA_W-1] ^ sub_ovf;

  always_comb begin
    out = '0;
    case (op)
      OP_ADD:  out = add_sum;
      OP_SUB:  out = sub_sum;
      OP_NOT:  out = {1'b0, ~a};
      OP_AND:  out = {1'b0, a & b};
      OP_OR:   out = {1'b0, a | b};
      OP_XOR:  out = {1'b0, a ^ b};
      OP_SLT:  out = {{(RES_W-1){1'b0}}, lt};
      OP_EQ:   out = {{(RES_W-1){1'b0}}, (a == b)};
      default: out = '0;
    endcase
  end

  assign cf = sum[RES_W-1];
  assign sf = sum[DATA_W-1];
  assign of = cf ^ sf;
  assign zf = (a == b);

endmodule

// File: rtl/alu_sched.sv
// alu_sched -- two-requester front end that arbitrates access to one ALU.
// A request is granted in IDLE (ready is combinational), its operands are
// latched, the result is registered in EXEC, and presented in RESP until
// the consumer takes it. Accept in cycle N gives resp_valid in cycle N+2.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req{0,1}_valid/_ready       request handshake per requester
//   req{0,1}_sel/_a/_b          opcode and operands per requester
//   resp_valid/resp_ready       response handshake
//   resp_id, resp_out,          owner, result and {OF,ZF,CF,SF}; all zero
//   resp_flags                  while resp_valid is low
//   busy                        FSM is not in IDLE
// Parameter FIXED_PRIO: 0 = round-robin, 1 = requester 0 always wins.
module alu_sched
  import alu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [RES_W-1:0]  resp_out,
  output logic [FLAG_W-1:0] resp_flags,
  output logic              busy
);

  state_t              state;
  logic                rr_ptr;     // requester preferred on the next tie
  logic                any_req;
  logic                grant_id;
  logic                accept;

  logic [2:0]          sel_p0;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic                id_p0;

  logic [RES_W-1:0]    out_p1;
  logic [FLAG_W-1:0]   flags_p1;
  logic                id_p1;
  logic                vld_p1;

  logic [RES_W-1:0]    core_out;
  logic                core_of;
  logic                core_zf;
  logic                core_cf;
  logic                core_sf;

  // Arbitration: a lone requester always wins; on a tie the round-robin
  // pointer decides unless fixed priority is selected.
  always_comb begin
    any_req  = req0_valid | req1_valid;
    grant_id = ~req0_valid;
    if (FIXED_PRIO == 0) begin
      if (req0_valid && req1_valid) grant_id = rr_ptr;
    end
  end

  assign accept = (state == S_IDLE) & any_req;

  // Readys are gated by rst so every output reads 0 while reset is held.
  assign req0_ready = ~rst & accept & ~grant_id;
  assign req1_ready = ~rst & accept &  grant_id;

  alu_core u_core (
    .sel (sel_p0),
    .a   (a_p0),
    .b   (b_p0),
    .out (core_out),
    .of  (core_of),
    .zf  (core_zf),
    .cf  (core_cf),
    .sf  (core_sf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= 1'b0;
      sel_p0   <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      id_p0    <= 1'b0;
      out_p1   <= '0;
      flags_p1 <= '0;
      id_p1    <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        // ---- p0: capture the granted request's operands ----
        S_IDLE: begin
          if (accept) begin
            sel_p0 <= grant_id ? req1_sel : req0_sel;
            a_p0   <= grant_id ? req1_a   : req0_a;
            b_p0   <= grant_id ? req1_b   : req0_b;
            id_p0  <= grant_id;
            rr_ptr <= ~grant_id;
            state  <= S_EXEC;
          end
        end
        // ---- p1: register the ALU result from the latched operands ----
        S_EXEC: begin
          out_p1   <= core_out;
          flags_p1 <= pack_flags(core_of, core_zf, core_cf, core_sf);
          id_p1    <= id_p0;
          vld_p1   <= 1'b1;
          state    <= S_RESP;
        end
        // ---- hold the response until the consumer takes it ----
        S_RESP: begin
          if (resp_ready) begin
            out_p1   <= '0;
            flags_p1 <= '0;
            id_p1    <= 1'b0;
            vld_p1   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = vld_p1;
  assign resp_id    = id_p1;
  assign resp_out   = out_p1;
  assign resp_flags = flags_p1;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_sel, req1_sel;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp_valid, resp_ready, resp_id, busy;
  logic [4:0] resp_out;
  logic [3:0] resp_flags;

  alu_sched #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_out(resp_out), .resp_flags(resp_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int id;
    int out;
    int flags;
    int acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   outstanding = 0;  // an op has been accepted and not yet taken
  bit   release_req = 0;  // monitor saw the response handshake
  bit   in_reset = 1;
  int   ptr = 0;          // requester that wins the next tie

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference ALU from the opcode definitions, using plain integers.
  function automatic void model(input int sel, input int a, input int b,
                                output int out, output int flags);
    int sum, sa, sb, cf, sf, zf;
    if (sel == 0) sum = (a + b) & 31;
    else          sum = (a + ((~b) & 15) + 1) & 31;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    case (sel)
      0, 1:    out = sum;
      2:       out = (~a) & 15;
      3:       out = a & b;
      4:       out = a | b;
      5:       out = a ^ b;
      6:       out = (sa < sb) ? 1 : 0;
      default: out = (a == b) ? 1 : 0;
    endcase
    cf = (sum >> 4) & 1;
    sf = (sum >> 3) & 1;
    zf = (a == b) ? 1 : 0;
    flags = ((cf ^ sf) << 3) | (zf << 2) | (cf << 1) | sf;
  endfunction

  // One bus cycle: drive after the rising edge, check grants at the falling edge.
  task automatic cyc(input int v0, input int s0, input int a0, input int b0,
                     input int v1, input int s1, input int a1, input int b1,
                     input int rr);
    int win, e0, e1, o, f;
    @(posedge clk);
    if (release_req) begin
      outstanding = 0;
      release_req = 0;
    end
    #1;
    req0_valid = v0[0]; req0_sel = 3'(s0); req0_a = 4'(a0); req0_b = 4'(b0);
    req1_valid = v1[0]; req1_sel = 3'(s1); req1_a = 4'(a1); req1_b = 4'(b1);
    resp_ready = rr[0];
    @(negedge clk);
    e0 = 0; e1 = 0; win = -1;
    if (!outstanding && (v0 != 0 || v1 != 0)) begin
      if (v0 != 0 && v1 != 0) win = ptr;
      else                    win = (v0 != 0) ? 0 : 1;
      if (win == 0) e0 = 1; else e1 = 1;
    end
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("busy", busy, outstanding);
    if (win >= 0) begin
      if (win == 0) model(s0, a0, b0, o, f);
      else          model(s1, a1, b1, o, f);
      q.push_back('{id: win, out: o, flags: f, acc: cycle});
      outstanding = 1;
      ptr = 1 - win;
    end
  endtask

  task automatic idle(input int n, input int rr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, rr);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        bit expv;
        expv = (q.size() > 0) && (cycle >= q[0].acc + 2);
        check("resp_valid", resp_valid, expv);
        if (expv) begin
          check("resp_id", resp_id, q[0].id);
          check("resp_out", resp_out, q[0].out);
          check("resp_flags", resp_flags, q[0].flags);
          if (resp_ready) begin
            void'(q.pop_front());
            release_req = 1;
          end
        end else begin
          check("idle_resp_id", resp_id, 0);
          check("idle_resp_out", resp_out, 0);
          check("idle_resp_flags", resp_flags, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished (cycle %0d)", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    req0_valid = 1; req1_valid = 1;
    req0_sel = 0; req0_a = 4'd3; req0_b = 4'd4;
    req1_sel = 0; req1_a = 4'd5; req1_b = 4'd6;
    resp_ready = 0;
    #12;
    // Held reset: everything reads 0 even with requests pending.
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_out", resp_out, 0);
    check("rst_resp_flags", resp_flags, 0);
    check("rst_resp_id", resp_id, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    in_reset = 0;

    // add 7+9 from requester 0
    cyc(1, 0, 7, 9, 0, 0, 0, 0, 1);
    idle(3, 1);
    // sub 3-5 from requester 1
    cyc(0, 0, 0, 0, 1, 1, 3, 5, 1);
    idle(3, 1);
    // signed compare, equality, not
    cyc(1, 6, 2, 5, 0, 0, 0, 0, 1);  idle(2, 1);
    cyc(1, 7, 9, 9, 0, 0, 0, 0, 1);  idle(2, 1);
    cyc(1, 2, 10, 0, 0, 0, 0, 0, 1); idle(2, 1);
    cyc(1, 6, 8, 7, 0, 0, 0, 0, 1);  idle(2, 1);

    // Both requesting continuously: alternating grants, one per 3 cycles.
    for (int i = 0; i < 12; i++) cyc(1, 3, 12, 10, 1, 4, 12, 3, 1);
    idle(3, 1);

    // Consumer stalls in RESP; operands change after acceptance.
    cyc(0, 0, 0, 0, 1, 5, 6, 3, 0);
    cyc(0, 0, 0, 0, 1, 5, 15, 15, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, i, i, 1, 1, i, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2, 1);

    // Reset during EXEC aborts the op; the next tie goes to requester 0.
    cyc(1, 0, 1, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    in_reset = 1;
    rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_resp_out", resp_out, 0);
    check("abort_req0_ready", req0_ready, 0);
    check("abort_req1_ready", req1_ready, 0);
    q.delete();
    outstanding = 0;
    release_req = 0;
    ptr = 0;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    in_reset = 0;
    idle(3, 1);
    cyc(1, 5, 9, 6, 1, 5, 1, 2, 1);
    idle(3, 1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
          ($urandom_range(0, 3) != 0) ? 1 : 0);
    end

    // Drain.
    for (int i = 0; i < 10 && (q.size() > 0); i++) idle(1, 1);
    idle(1, 1);
    check("drain_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
